// File: rtl/game_round_pkg.sv
//------------------------------------------------------------------------------
// Module  : game_round_pkg
// Brief   : Shared round-state encoding and channel-index width helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package game_round_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } round_state_t;

    // Index width for an n-channel vector; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_lsb.sv
//------------------------------------------------------------------------------
// Module  : prio_enc_lsb
// Brief   : Combinational lowest-set-bit priority encoder with any-set flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prio_enc_lsb
    import game_round_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ch_w(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // Scan downward so the lowest set index is the last to assign.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_round_latch.sv
//------------------------------------------------------------------------------
// Module  : game_round_latch
// Brief   : Multi-player round controller: arms a round, latches sticky press
//           flags, captures the first presser and times out idle rounds.
//           Optional macro GAME_ROUND_EDGE_EN qualifies presses by rising edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_round_latch
    import game_round_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int TIMEOUT_W = 16,
    localparam int CH_W      = ch_w(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [N_CH-1:0]      ctrl,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    output logic                 active,
    output logic [N_CH-1:0]      flags,
    output logic [CH_W-1:0]      winner,
    output logic                 winner_valid,
    output logic                 timed_out,
    output logic                 done_pulse
);

    round_state_t         r_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [N_CH-1:0]      r_flags;
    logic [CH_W-1:0]      r_winner;
    logic                 r_winner_valid;
    logic                 r_timed_out;
    logic                 r_done_pulse;

    logic [N_CH-1:0]      w_qual;
    logic [CH_W-1:0]      w_idx;
    logic                 w_any;
    logic [TIMEOUT_W-1:0] w_lim_m1;

`ifdef GAME_ROUND_EDGE_EN
    logic [N_CH-1:0]      r_ctrl_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_q <= '0;
        end else begin
            r_ctrl_q <= ctrl;
        end
    end

    assign w_qual = ctrl & ~r_ctrl_q;
`else
    assign w_qual = ctrl;
`endif

    assign w_lim_m1 = timeout_lim - TIMEOUT_W'(1);

    prio_enc_lsb #(
        .N (N_CH),
        .W (CH_W)
    ) u_prio (
        .i_vec (w_qual),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Per-cycle priority: clear, then start, then press, then timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_flags        <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_timed_out    <= 1'b0;
            r_done_pulse   <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (clear) begin
                r_state        <= IDLE;
                r_cnt          <= '0;
                r_flags        <= '0;
                r_winner_valid <= 1'b0;
                r_timed_out    <= 1'b0;
            end else if (start) begin
                r_state        <= ACTIVE;
                r_cnt          <= '0;
                r_flags        <= '0;
                r_winner_valid <= 1'b0;
                r_timed_out    <= 1'b0;
            end else begin
                case (r_state)
                    ACTIVE: begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + TIMEOUT_W'(1);
                        end
                        r_flags <= r_flags | w_qual;
                        if (w_any) begin
                            r_winner       <= w_idx;
                            r_winner_valid <= 1'b1;
                            r_done_pulse   <= 1'b1;
                            r_state        <= DONE;
                        end else if ((timeout_lim != '0) && (r_cnt == w_lim_m1)) begin
                            r_timed_out  <= 1'b1;
                            r_done_pulse <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                    DONE: begin
                        r_flags <= r_flags | w_qual;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign active       = (r_state == ACTIVE);
    assign flags        = r_flags;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign timed_out    = r_timed_out;
    assign done_pulse   = r_done_pulse;

endmodule

`default_nettype wire
